seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 90 +++++++++
 tb/tb_seq_shifter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-shifter replacement: one bit per SHIFT cycle, or four bits
// per cycle while count>=4 when SEQ_SHIFTER_FAST_EN is defined.
module seq_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic [1:0]  shtype,
  output logic        busy,
  output logic        done,
  output logic [31:0] y
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | stepping data, count holds remaining bits
  // DONE  | y valid, done pulsed; start here chains the next op
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] data, data_shf;
  logic [4:0]  count, count_nxt, step;
  logic [1:0]  kind;
  logic        accept, quick, last;

  always_comb begin
`ifdef SEQ_SHIFTER_FAST_EN
    step = (count >= 5'd4) ? 5'd4 : 5'd1;
`else
    step = 5'd1;
`endif
    count_nxt = count - step;
    case (kind)
      2'b00:   data_shf = data << step;
      2'b01:   data_shf = data >> step;
      2'b10:   data_shf = $signed(data) >>> step;
      default: data_shf = data;
    endcase
  end

  assign accept = start && (state != SHIFT);
  assign quick  = (shamt == 5'd0) || (shtype == 2'b11);
  assign last   = (state == SHIFT) && (count_nxt == 5'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = quick ? DONE : SHIFT;
        else
          state_nxt = IDLE;
      end
      SHIFT: if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data  <= 32'd0;
      count <= 5'd0;
      kind  <= 2'b00;
      y     <= 32'd0;
    end else begin
      state <= state_nxt;
      // A flushed cycle leaves all datapath registers, and y, untouched.
      if (!flush) begin
        if (accept) begin
          data  <= a;
          count <= shamt;
          kind  <= shtype;
          if (quick) y <= a;
        end else if (state == SHIFT) begin
          data  <= data_shf;
          count <= count_nxt;
          if (last) y <= data_shf;
        end
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: the driver queues expected y and done cycle,
// a negedge monitor pops on every done pulse.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  shtype;
  logic        busy, done;
  logic [31:0] y;

  seq_shifter dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .a(a), .shamt(shamt), .shtype(shtype),
    .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   issued = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [4:0] s, input logic [1:0] t);
    int n;
    n = int'(s);
    if (n == 0 || t == 2'b11) return 1;
`ifdef SEQ_SHIFTER_FAST_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("y", y, e.y);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle (cycle 0), return at #1 into the done cycle.
  // poke: raise start with junk operands in cycle 1, which must be ignored.
  task automatic run_op(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] tv,
                        input logic [31:0] yexp, input bit poke);
    int   lat;
    exp_t e;
    lat   = lat_of(sv, tv);
    e.y   = yexp;
    e.cyc = cyc + lat;
    sb.push_back(e);
    issued++;
    start = 1'b1; a = av; shamt = sv; shtype = tv;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (poke && k == 1) begin
        start = 1'b1; a = 32'hFFFF_FFFF; shamt = 5'd1; shtype = 2'b00;
      end else begin
        start = 1'b0;
      end
      if (k < lat) check("busy_shift", {31'd0, busy}, 32'd1);
    end
    check("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    a = 32'd0; shamt = 5'd0; shtype = 2'b00;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_y", y, 32'd0);
    reset = 1'b0;
    tick();

    run_op(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0); tick();
    run_op(32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0); tick();
    run_op(32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1'b0); tick();
    run_op(32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0); tick();
    run_op(32'hCAFE_F00D, 5'd9,  2'b11, 32'hCAFE_F00D, 1'b0); tick();
    run_op(32'hF000_000F, 5'd7,  2'b10, 32'hFFE0_0000, 1'b0); tick();
    run_op(32'hF000_000F, 5'd5,  2'b00, 32'h0000_01E0, 1'b0); tick();

    // back-to-back: second start lands in the first op's DONE cycle
    run_op(32'h0000_0001, 5'd2, 2'b00, 32'h0000_0004, 1'b0);
    run_op(32'h0000_0100, 5'd4, 2'b01, 32'h0000_0010, 1'b1);
    tick();
    check("idle_after_b2b", {31'd0, busy}, 32'd0);

    // flush mid-operation in cycle 5
    start = 1'b1; a = 32'h1; shamt = 5'd20; shtype = 2'b00;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("busy_before_flush", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_y", y, 32'h0000_0010);
    repeat (20) tick();
    check("flush_y_later", y, 32'h0000_0010);

    // flush beats a simultaneous start
    start = 1'b1; flush = 1'b1; a = 32'h5; shamt = 5'd3; shtype = 2'b00;
    tick(); start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    check("flush_start_done", {31'd0, done}, 32'd0);
    repeat (6) tick();
    check("flush_start_y", y, 32'h0000_0010);

    // reset mid-operation in cycle 3
    start = 1'b1; a = 32'h1; shamt = 5'd20; shtype = 2'b00;
    tick(); start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_y", y, 32'd0);
    repeat (22) tick();
    check("rst_mid_y_later", y, 32'd0);
    run_op(32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006, 1'b0);

    repeat (4) tick();
    check("sb_empty", sb.size(), 32'd0);
    check("done_pulses", done_cnt, issued);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
